rcvr_frame_filter: RTL and testbench



---
 rtl/rcvr_frame_filter_if.sv | 15 +
 rtl/rcvr_frame_filter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rcvr_frame_filter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rcvr_frame_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rcvr_frame_filter_if : committed-byte stream (valid/ready, last marker)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rcvr_frame_filter_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/rcvr_frame_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rcvr_frame_filter : WimpFi frame filter with frame-committing FIFO       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rcvr_frame_filter #(
    parameter int         DEPTH          = 64,
    parameter logic [7:0] BROADCAST_ADDR = 8'h2A,
    parameter logic [7:0] TYPE_NOCRC     = 8'h30,
    parameter logic [7:0] TYPE_CRC       = 8'h31,
    parameter bit         STRIP_CRC      = 1'b1,
    parameter int         CNT_W          = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [7:0]       mac_addr,
    input  wire logic             promiscuous,
    input  wire logic             ignore_broadcast,
    input  wire logic             cardet,
    input  wire logic             byte_valid,
    input  wire logic [7:0]       byte_data,
    input  wire logic             rx_err,
    rcvr_frame_filter_if.master   out_if,
    output logic                  frame_good,
    output logic                  frame_bad,
    output logic [CNT_W-1:0]      good_cnt,
    output logic [CNT_W-1:0]      crc_err_cnt,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [CNT_W-1:0]      ovf_cnt,
    output logic [CNT_W-1:0]      rerr_cnt,
    output logic [2:0]            state
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        LOCK    = 3'd3,
        ENDF    = 3'd4
    } state_t;

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       cmt_ptr_q, cmt_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        crc_q, crc_d;
    logic              is_crc_q, is_crc_d;
    logic              ovf_q, ovf_d;
    logic              frame_good_q, frame_good_d;
    logic              frame_bad_q, frame_bad_d;
    logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  crc_err_cnt_q, crc_err_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]  rerr_cnt_q, rerr_cnt_d;

    logic [8:0]        mem [DEPTH];
    logic              w_mem_we;
    logic              w_last_we;
    logic [AW-1:0]     w_last_addr;
    logic              w_take;
    logic              w_full;
    logic              w_dest_ok;
    logic              w_type_ok;
    logic [AW:0]       w_cmt_new;
    logic              w_out_valid;
    logic [8:0]        w_rd_word;

    // Fullness uses the pre-edge read pointer, so a same-cycle read never frees space early.
    assign w_full    = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign w_dest_ok = (byte_data == mac_addr) || promiscuous ||
                       ((byte_data == BROADCAST_ADDR) && !ignore_broadcast);
    assign w_type_ok = (byte_data == TYPE_NOCRC) || (byte_data == TYPE_CRC);
    assign w_cmt_new = (is_crc_q && STRIP_CRC) ? (wr_ptr_q - PTR_ONE) : wr_ptr_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cmt_ptr_d     = cmt_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        is_crc_d      = is_crc_q;
        ovf_d         = ovf_q;
        frame_good_d  = 1'b0;
        frame_bad_d   = 1'b0;
        good_cnt_d    = good_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        ovf_cnt_d     = ovf_cnt_q;
        rerr_cnt_d    = rerr_cnt_q;
        w_mem_we      = 1'b0;
        w_last_we     = 1'b0;
        w_last_addr   = w_cmt_new[AW-1:0] - 1'b1;
        w_take        = 1'b0;

        if (w_out_valid && out_if.out_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (rx_err) begin
            rerr_cnt_d = sat_inc(rerr_cnt_q);
        end

        case (state_q)
            IDLE: begin
                wr_ptr_d = cmt_ptr_q;
                cnt_d    = 3'd0;
                crc_d    = 8'h00;
                is_crc_d = 1'b0;
                ovf_d    = 1'b0;
                if (cardet) state_d = HDR;
            end
            HDR: begin
                if (rx_err) begin
                    state_d = LOCK;
                end else begin
                    if (byte_valid) begin
                        w_take = 1'b1;
                        if (cnt_q == 3'd0 && !w_dest_ok) begin
                            w_take     = 1'b0;
                            drop_cnt_d = sat_inc(drop_cnt_q);
                            state_d    = LOCK;
                        end else if (cnt_q == 3'd2) begin
                            if (!w_type_ok) begin
                                w_take     = 1'b0;
                                drop_cnt_d = sat_inc(drop_cnt_q);
                                state_d    = LOCK;
                            end else begin
                                is_crc_d = (byte_data == TYPE_CRC);
                                state_d  = PAYLOAD;
                            end
                        end
                    end
                    // A short frame still reaches END so it is counted and rolled back there.
                    if (!cardet && state_d != LOCK) state_d = ENDF;
                end
            end
            PAYLOAD: begin
                if (rx_err) begin
                    state_d = LOCK;
                end else begin
                    w_take = byte_valid;
                    if (!cardet) state_d = ENDF;
                end
            end
            LOCK: begin
                wr_ptr_d = cmt_ptr_q;
                if (!cardet) state_d = IDLE;
            end
            ENDF: begin
                state_d = IDLE;
                if (ovf_q) begin
                    wr_ptr_d    = cmt_ptr_q;
                    ovf_cnt_d   = sat_inc(ovf_cnt_q);
                    frame_bad_d = 1'b1;
                end else if (cnt_q < 3'd3 || (is_crc_q && cnt_q < 3'd4)) begin
                    wr_ptr_d    = cmt_ptr_q;
                    drop_cnt_d  = sat_inc(drop_cnt_q);
                    frame_bad_d = 1'b1;
                end else if (is_crc_q && crc_q != 8'h00) begin
                    wr_ptr_d      = cmt_ptr_q;
                    crc_err_cnt_d = sat_inc(crc_err_cnt_q);
                    frame_bad_d   = 1'b1;
                end else begin
                    cmt_ptr_d    = w_cmt_new;
                    w_last_we    = 1'b1;
                    good_cnt_d   = sat_inc(good_cnt_q);
                    frame_good_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_take) begin
            cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
            crc_d = crc8_upd(crc_q, byte_data);
            if (!ovf_q) begin
                if (w_full) begin
                    ovf_d = 1'b1;
                end else begin
                    w_mem_we = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            cmt_ptr_q     <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= 3'd0;
            crc_q         <= 8'h00;
            is_crc_q      <= 1'b0;
            ovf_q         <= 1'b0;
            frame_good_q  <= 1'b0;
            frame_bad_q   <= 1'b0;
            good_cnt_q    <= '0;
            crc_err_cnt_q <= '0;
            drop_cnt_q    <= '0;
            ovf_cnt_q     <= '0;
            rerr_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cmt_ptr_q     <= cmt_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            is_crc_q      <= is_crc_d;
            ovf_q         <= ovf_d;
            frame_good_q  <= frame_good_d;
            frame_bad_q   <= frame_bad_d;
            good_cnt_q    <= good_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
            rerr_cnt_q    <= rerr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) mem[wr_ptr_q[AW-1:0]] <= {1'b0, byte_data};
        if (w_last_we) mem[w_last_addr][8] <= 1'b1;
    end

    assign w_out_valid      = (rd_ptr_q != cmt_ptr_q);
    assign w_rd_word        = mem[rd_ptr_q[AW-1:0]];
    assign out_if.out_valid = w_out_valid;
    assign out_if.out_data  = w_rd_word[7:0];
    assign out_if.out_last  = w_out_valid & w_rd_word[8];

    assign frame_good  = frame_good_q;
    assign frame_bad   = frame_bad_q;
    assign good_cnt    = good_cnt_q;
    assign crc_err_cnt = crc_err_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign rerr_cnt    = rerr_cnt_q;
    assign state       = state_q;
endmodule
`default_nettype wire

// File: tb/tb_rcvr_frame_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rcvr_frame_filter : directed frames, scoreboard on the output stream  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rcvr_frame_filter;
    localparam int DEPTH = 8;
    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mac_addr = 8'h10;
    logic       promiscuous = 1'b0;
    logic       ignore_broadcast = 1'b0;
    logic       cardet = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       rx_err = 1'b0;
    logic       frame_good, frame_bad;
    logic [7:0] good_cnt, crc_err_cnt, drop_cnt, ovf_cnt, rerr_cnt;
    logic [2:0] state;

    rcvr_frame_filter_if s_if ();

    rcvr_frame_filter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mac_addr(mac_addr), .promiscuous(promiscuous),
        .ignore_broadcast(ignore_broadcast), .cardet(cardet), .byte_valid(byte_valid),
        .byte_data(byte_data), .rx_err(rx_err), .out_if(s_if.master),
        .frame_good(frame_good), .frame_bad(frame_bad), .good_cnt(good_cnt),
        .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt),
        .rerr_cnt(rerr_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         good_pulses = 0;
    int         bad_pulses = 0;
    int         popped = 0;
    logic [8:0] exp_q [$];
    logic [3:0] exp_ptr = 4'd0;

    function automatic logic [7:0] crc8(input bq_t b);
        logic [7:0] r;
        r = 8'h00;
        foreach (b[k]) begin
            r = r ^ b[k];
            for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_good) good_pulses++;
            if (frame_bad) bad_pulses++;
            if (s_if.out_valid && s_if.out_ready) begin
                popped++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %0h, required none", {s_if.out_last, s_if.out_data});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({s_if.out_last, s_if.out_data} !== e) begin
                        fails++;
                        $display("FAIL out_byte: got %0h, required %0h", {s_if.out_last, s_if.out_data}, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        cardet = 1'b1;
        tick();
    endtask

    task automatic end_frame();
        cardet = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input bq_t b);
        start_frame();
        foreach (b[k]) send_byte(b[k]);
        end_frame();
    endtask

    // Queue the bytes that should come out, last flag on the final one.
    task automatic expect_bytes(input bq_t b);
        foreach (b[k]) exp_q.push_back({(k == b.size() - 1), b[k]});
        exp_ptr = exp_ptr + 4'(b.size());
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !s_if.out_valid) break;
            tick();
        end
        check(name, exp_q.size() + {31'd0, s_if.out_valid}, 0);
    endtask

    initial begin
        bq_t f, g;
        int gp, bp, pp;
        s_if.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", s_if.out_valid, 0);
        check("rst_out_last", s_if.out_last, 0);
        check("rst_state", state, 0);
        check("rst_counters", {good_cnt, crc_err_cnt, drop_cnt, ovf_cnt, rerr_cnt}, 0);
        check("rst_pulses", {frame_good, frame_bad}, 0);
        rst_n = 1'b1;
        tick();

        // Good CRC frame, CRC byte stripped
        f = '{8'h10, 8'h55, 8'h31, 8'hA1, 8'hB2};
        g = f;
        g.push_back(crc8(f));
        gp = good_pulses; pp = popped;
        expect_bytes(f);
        send_frame(g);
        drain("t1_drain");
        check("t1_delivered", popped - pp, 5);
        check("t1_good_pulse", good_pulses - gp, 1);
        check("t1_good_cnt", good_cnt, 1);

        // Same frame, corrupted CRC
        g[5] = ~g[5];
        bp = bad_pulses; pp = popped;
        send_frame(g);
        check("t2_bad_pulse", bad_pulses - bp, 1);
        check("t2_crc_err_cnt", crc_err_cnt, 1);
        check("t2_out_valid", s_if.out_valid, 0);
        check("t2_wr_ptr", dut.wr_ptr_q, exp_ptr);
        check("t2_cmt_ptr", dut.cmt_ptr_q, exp_ptr);
        check("t2_delivered", popped - pp, 0);

        // Broadcast rejected, LOCK holds until carrier drops
        ignore_broadcast = 1'b1;
        start_frame();
        send_byte(8'h2A);
        check("t3_lock", state, 3);
        send_byte(8'h55); send_byte(8'h30); send_byte(8'h01);
        check("t3_lock_hold", state, 3);
        end_frame();
        check("t3_drop_cnt", drop_cnt, 1);
        f = '{8'h10, 8'h66, 8'h30, 8'hC3};
        expect_bytes(f);
        send_frame(f);
        drain("t3_drain");
        check("t3_good_cnt", good_cnt, 2);
        ignore_broadcast = 1'b0;

        // Two-byte frame is too short
        bp = bad_pulses;
        send_frame('{8'h10, 8'h07});
        check("t3b_drop_cnt", drop_cnt, 2);
        check("t3b_bad_pulse", bad_pulses - bp, 1);

        // Overflow: second frame cannot fit behind the first
        s_if.out_ready = 1'b0;
        f = '{8'h10, 8'h01, 8'h30, 8'h11, 8'h12, 8'h13};
        expect_bytes(f);
        send_frame(f);
        bp = bad_pulses;
        send_frame('{8'h10, 8'h02, 8'h30, 8'h21, 8'h22, 8'h23});
        check("t4_ovf_cnt", ovf_cnt, 1);
        check("t4_bad_pulse", bad_pulses - bp, 1);
        check("t4_good_cnt", good_cnt, 3);
        check("t4_out_valid", s_if.out_valid, 1);
        check("t4_cmt_ptr", dut.cmt_ptr_q, exp_ptr);
        s_if.out_ready = 1'b1;
        drain("t4_drain");

        // Receiver error mid-payload aborts silently
        gp = good_pulses; bp = bad_pulses; pp = popped;
        start_frame();
        send_byte(8'h10); send_byte(8'h03); send_byte(8'h30); send_byte(8'h44);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        send_byte(8'h45);
        end_frame();
        check("t5_rerr_cnt", rerr_cnt, 1);
        check("t5_pulses", (good_pulses - gp) + (bad_pulses - bp), 0);
        check("t5_no_output", popped - pp + {31'd0, s_if.out_valid}, 0);
        f = '{8'h10, 8'h04, 8'h31, 8'h77};
        g = f;
        g.push_back(crc8(f));
        expect_bytes(f);
        send_frame(g);
        drain("t5_drain");
        check("t5_good_cnt", good_cnt, 4);

        // Asynchronous reset with committed data pending
        s_if.out_ready = 1'b0;
        send_frame('{8'h10, 8'h05, 8'h30, 8'h99});
        check("t6_pending", s_if.out_valid, 1);
        start_frame();
        send_byte(8'h10); send_byte(8'h06);
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", s_if.out_valid, 0);
        check("t6_state", state, 0);
        check("t6_counters", {good_cnt, crc_err_cnt, drop_cnt, ovf_cnt, rerr_cnt}, 0);
        cardet = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_ptr = 4'd0;
        s_if.out_ready = 1'b1;
        tick();
        f = '{8'h10, 8'h08, 8'h30, 8'h5A};
        expect_bytes(f);
        send_frame(f);
        drain("t6_drain");
        check("t6_good_cnt", good_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
